// File: rtl/eem16_proj3_pkg.sv
// Shared constants for the 15-cent vending controller: state encodings, coin
// codes and the pure next-state / output functions used by the top level.
package eem16_proj3_pkg;

    localparam logic [2:0] S0  = 3'b000;
    localparam logic [2:0] S5  = 3'b001;
    localparam logic [2:0] S10 = 3'b010;
    localparam logic [2:0] S15 = 3'b011;
    localparam logic [2:0] S20 = 3'b100;

    typedef enum logic [1:0] {
        COIN_NONE    = 2'b00,
        COIN_NICKEL  = 2'b01,
        COIN_INVALID = 2'b10,
        COIN_DIME    = 2'b11
    } coin_e;

    typedef struct packed {
        logic dispense;
        logic change;
    } vend_out_t;

    // The invalid code falls into the default arm everywhere, so it credits nothing.
    function automatic logic [2:0] next_state_f(logic [2:0] state, coin_e coin);
        logic [2:0] nxt;
        // NOTE: a default assignment up front means every path writes nxt,
        // so no latch is inferred when this is called from always_comb.
        nxt = S0;
        case (state)
            S0, S15, S20: begin
                case (coin)
                    COIN_NICKEL: nxt = S5;
                    COIN_DIME:   nxt = S10;
                    default:     nxt = S0;
                endcase
            end
            S5: begin
                case (coin)
                    COIN_NICKEL: nxt = S10;
                    COIN_DIME:   nxt = S15;
                    default:     nxt = S5;
                endcase
            end
            S10: begin
                case (coin)
                    COIN_NICKEL: nxt = S15;
                    COIN_DIME:   nxt = S20;
                    default:     nxt = S10;
                endcase
            end
            default: nxt = S0;
        endcase
        return nxt;
    endfunction

    function automatic vend_out_t decode_out_f(logic [2:0] state);
        vend_out_t o;
        o.dispense = (state == S15) || (state == S20);
        o.change   = (state == S20);
        return o;
    endfunction

endpackage

// File: rtl/eem16_proj3_if.sv
// Coin-in / vend-out signal bundle between a coin source and the controller.
interface eem16_proj3_if;
    logic x1;
    logic x0;
    logic z1;
    logic z0;

    modport master (output x1, output x0, input z1, input z0);
    modport slave  (input x1, input x0, output z1, output z0);
endinterface

// File: rtl/jk_ff.sv
// JK flip-flop with asynchronous active-low clear; one bit of controller state.
module jk_ff (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);

    // NOTE: state is written with non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/eem16_proj3.sv
// Moore vending controller: nickels/dimes accumulate to 15c, then one dispense
// cycle (plus change at 20c). State lives in three JK flops.
module eem16_proj3
    import eem16_proj3_pkg::*;
(
    input  logic clk,
    input  logic r,
    input  logic x1,
    input  logic x0,
    output logic z1,
    output logic z0
);

    logic [2:0] state;
    logic [2:0] next_state;
    logic [2:0] j;
    logic [2:0] k;
    coin_e      coin;
    vend_out_t  vend;

    assign coin = coin_e'({x1, x0});

    // JK excitation: set bits that must rise, clear bits that must fall, hold the rest.
    always_comb begin
        next_state = next_state_f(state, coin);
        j          = ~state & next_state;
        k          = state & ~next_state;
    end

    for (genvar i = 0; i < 3; i++) begin : g_state_ff
        jk_ff u_ff (
            .clk   (clk),
            .rst_n (r),
            .j     (j[i]),
            .k     (k[i]),
            .q     (state[i])
        );
    end

    assign vend = decode_out_f(state);
    assign z1   = vend.dispense;
    assign z0   = vend.change;

endmodule

// File: tb/tb_eem16_proj3.sv
// Self-checking bench: credit-in-cents reference model against the controller,
// directed scenarios followed by randomized coins and asynchronous resets.
module tb_eem16_proj3;
    import eem16_proj3_pkg::*;

    logic clk = 1'b0;
    logic r;
    int   checks = 0;
    int   errors = 0;
    int   credit = 0;

    eem16_proj3_if bus ();

    eem16_proj3 dut (
        .clk (clk),
        .r   (r),
        .x1  (bus.x1),
        .x0  (bus.x0),
        .z1  (bus.z1),
        .z0  (bus.z0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int coin_value(input logic [1:0] c);
        case (c)
            2'b01:   return 5;
            2'b11:   return 10;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] credit_state(input int c);
        case (c)
            5:       return S5;
            10:      return S10;
            15:      return S15;
            20:      return S20;
            default: return S0;
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".z1"}, {2'b00, bus.z1}, {2'b00, credit >= 15});
        check({tag, ".z0"}, {2'b00, bus.z0}, {2'b00, credit == 20});
        check({tag, ".state"}, dut.state, credit_state(credit));
    endtask

    // Present a coin code for one rising edge, advance the model, check after the edge.
    task automatic apply(input logic [1:0] c, input string tag);
        {bus.x1, bus.x0} = c;
        @(posedge clk);
        if (r) credit = ((credit >= 15) ? 0 : credit) + coin_value(c);
        #1;
        check_outputs(tag);
    endtask

    // Drop reset mid-cycle, check the immediate clear, hold for a few edges, release.
    task automatic async_reset(input int hold, input string tag);
        #2 r = 1'b0;
        credit = 0;
        #1 check_outputs({tag, ".now"});
        for (int i = 0; i < hold; i++) apply(2'b11, {tag, ".held"});
        r = 1'b1;
    endtask

    initial begin
        r = 1'b0;
        {bus.x1, bus.x0} = 2'b00;
        #12;
        check_outputs("reset");
        r = 1'b1;
        apply(2'b00, "idle");

        apply(2'b11, "dime_a");
        apply(2'b01, "nickel_completes");
        apply(2'b11, "dime_after_vend");
        apply(2'b01, "nickel_to_15");
        apply(2'b00, "clear_to_0");

        for (int i = 0; i < 4; i++) apply(2'b01, "nickel_x4");
        apply(2'b01, "nickel_s10");
        apply(2'b01, "nickel_s15");
        apply(2'b00, "none_s0");

        apply(2'b11, "dime_1");
        apply(2'b11, "dime_2_change");
        apply(2'b00, "after_change");

        apply(2'b11, "dime_pre_rst");
        async_reset(2, "rst_mid");
        apply(2'b01, "nickel_post_rst");

        apply(2'b10, "invalid_s5");
        apply(2'b11, "dime_s15");
        apply(2'b10, "invalid_s15");

        apply(2'b11, "dime_to_s10");
        apply(2'b11, "dime_to_s20");
        async_reset(0, "rst_in_s20");
        apply(2'b10, "invalid_after_rst");

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                async_reset($urandom_range(0, 2), "rand_rst");
            end else begin
                apply(2'($urandom_range(0, 3)), "rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
